// File: rtl/calc_entry_fsm.sv
// Hex calculator key-entry controller: collects two operands and an operator
// from one-cycle key events, then computes and holds the result for display.
module calc_entry_fsm #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [4:0]       val,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [2:0]       op_code,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] display_value,
  output logic [1:0]       state,
  output logic             result_valid,
  output logic             overflow
);

  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  localparam logic [4:0] KEY_ADD  = 5'h10;
  localparam logic [4:0] KEY_MULT = 5'h11;
  localparam logic [4:0] KEY_AND  = 5'h12;
  localparam logic [4:0] KEY_EXE  = 5'h13;
  localparam logic [4:0] KEY_SUB  = 5'h14;
  localparam logic [4:0] KEY_OR   = 5'h15;
  localparam logic [4:0] KEY_CE   = 5'h16;
  localparam logic [4:0] KEY_CLR  = 5'h17;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MULT = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;

  typedef enum logic [1:0] {
    ENTER_A     = 2'd0,
    ENTER_B     = 2'd1,
    SHOW_RESULT = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   a_cnt;
  logic [CW-1:0]   b_cnt;

  logic            is_digit;
  logic            is_op;
  logic [2:0]      key_op;
  logic [WIDTH-1:0] digit_ext;
  logic            do_clear;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;

  assign state     = state_q;
  assign is_digit  = ~val[4];
  assign digit_ext = WIDTH'(val[3:0]);

  // Unreachable encoding 3 falls back to the reset values on the next edge.
  assign do_clear = rst || (state_q == state_t'(2'd3)) || (sel && val == KEY_CLR);

  always_comb begin
    is_op  = 1'b1;
    key_op = OP_ADD;
    case (val)
      KEY_ADD:  key_op = OP_ADD;
      KEY_SUB:  key_op = OP_SUB;
      KEY_MULT: key_op = OP_MULT;
      KEY_AND:  key_op = OP_AND;
      KEY_OR:   key_op = OP_OR;
      default:  is_op  = 1'b0;
    endcase
  end

  always_comb begin
    sum     = {1'b0, operand_a} + {1'b0, operand_b};
    prod    = {{WIDTH{1'b0}}, operand_a} * {{WIDTH{1'b0}}, operand_b};
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_code)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_ovf = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = operand_a - operand_b;
        alu_ovf = operand_a < operand_b;
      end
      OP_MULT: begin
        alu_res = prod[WIDTH-1:0];
        alu_ovf = |prod[2*WIDTH-1:WIDTH];
      end
      OP_AND:  alu_res = operand_a & operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    display_value = '0;
    case (state_q)
      ENTER_A:     display_value = operand_a;
      ENTER_B:     display_value = (b_cnt != '0) ? operand_b : operand_a;
      SHOW_RESULT: display_value = result;
      default:     display_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_clear) begin
      state_q      <= ENTER_A;
      operand_a    <= '0;
      operand_b    <= '0;
      a_cnt        <= '0;
      b_cnt        <= '0;
      op_code      <= OP_ADD;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (sel) begin
        case (state_q)
          ENTER_A: begin
            if (is_digit) begin
              if (a_cnt != CNT_FULL) begin
                operand_a <= (operand_a << 4) | digit_ext;
                a_cnt     <= a_cnt + CW'(1);
              end
            end else if (is_op) begin
              op_code   <= key_op;
              operand_b <= '0;
              b_cnt     <= '0;
              state_q   <= ENTER_B;
            end else if (val == KEY_CE) begin
              operand_a <= '0;
              a_cnt     <= '0;
              overflow  <= 1'b0;
            end
          end
          ENTER_B: begin
            if (is_digit) begin
              if (b_cnt != CNT_FULL) begin
                operand_b <= (operand_b << 4) | digit_ext;
                b_cnt     <= b_cnt + CW'(1);
              end
            end else if (is_op) begin
              if (b_cnt == '0) op_code <= key_op;
            end else if (val == KEY_EXE) begin
              result       <= alu_res;
              overflow     <= alu_ovf;
              result_valid <= 1'b1;
              state_q      <= SHOW_RESULT;
            end else if (val == KEY_CE) begin
              operand_b <= '0;
              b_cnt     <= '0;
              overflow  <= 1'b0;
            end
          end
          SHOW_RESULT: begin
            // Every exit from here drops the sticky overflow of the old result.
            if (is_digit) begin
              operand_a <= digit_ext;
              a_cnt     <= CW'(1);
              operand_b <= '0;
              b_cnt     <= '0;
              overflow  <= 1'b0;
              state_q   <= ENTER_A;
            end else if (is_op) begin
              operand_a <= result;
              a_cnt     <= CNT_FULL;
              op_code   <= key_op;
              operand_b <= '0;
              b_cnt     <= '0;
              overflow  <= 1'b0;
              state_q   <= ENTER_B;
            end else if (val == KEY_CE) begin
              operand_a <= '0;
              a_cnt     <= '0;
              overflow  <= 1'b0;
              state_q   <= ENTER_A;
            end
          end
          default: state_q <= ENTER_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed key-sequence bench for calc_entry_fsm with hand-computed expectations.
module tb_calc_entry_fsm;

  localparam int WIDTH = 16;

  localparam logic [4:0] K_ADD  = 5'h10;
  localparam logic [4:0] K_MULT = 5'h11;
  localparam logic [4:0] K_AND  = 5'h12;
  localparam logic [4:0] K_EXE  = 5'h13;
  localparam logic [4:0] K_SUB  = 5'h14;
  localparam logic [4:0] K_OR   = 5'h15;
  localparam logic [4:0] K_CE   = 5'h16;
  localparam logic [4:0] K_CLR  = 5'h17;

  logic             clk;
  logic             rst;
  logic             sel;
  logic [4:0]       val;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] display_value;
  logic [1:0]       state;
  logic             result_valid;
  logic             overflow;

  int cmp_count;
  int err_count;

  calc_entry_fsm #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .sel           (sel),
    .val           (val),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .op_code       (op_code),
    .result        (result),
    .display_value (display_value),
    .state         (state),
    .result_valid  (result_valid),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    cmp_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One key event: sel high across exactly one rising edge, then sample 1ns later.
  task automatic applyStimulus(input logic [4:0] key);
    sel = 1'b1;
    val = key;
    @(posedge clk);
    #1;
    sel = 1'b0;
    val = 5'h00;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cmp_count = 0;
    err_count = 0;
    rst = 1'b1;
    sel = 1'b0;
    val = 5'h00;
    idleCycle();
    idleCycle();
    rst = 1'b0;

    checkOutput("reset_state",   32'(state), 32'd0);
    checkOutput("reset_a",       32'(operand_a), 32'h0);
    checkOutput("reset_b",       32'(operand_b), 32'h0);
    checkOutput("reset_result",  32'(result), 32'h0);
    checkOutput("reset_op",      32'(op_code), 32'd0);
    checkOutput("reset_ovf",     32'(overflow), 32'd0);
    checkOutput("reset_valid",   32'(result_valid), 32'd0);
    checkOutput("reset_display", 32'(display_value), 32'h0);

    // 0x12 + 0x34
    applyStimulus(5'h1);
    applyStimulus(5'h2);
    applyStimulus(5'h18);
    checkOutput("invalid_in_a", 32'(operand_a), 32'h12);
    applyStimulus(K_EXE);
    checkOutput("exe_in_a_state", 32'(state), 32'd0);
    checkOutput("exe_in_a_valid", 32'(result_valid), 32'd0);
    applyStimulus(K_ADD);
    checkOutput("add_state",      32'(state), 32'd1);
    checkOutput("add_display_a",  32'(display_value), 32'h12);
    applyStimulus(5'h3);
    applyStimulus(5'h4);
    checkOutput("b_display",      32'(display_value), 32'h34);
    applyStimulus(K_EXE);
    checkOutput("add_result",     32'(result), 32'h46);
    checkOutput("add_ovf",        32'(overflow), 32'd0);
    checkOutput("add_valid_hi",   32'(result_valid), 32'd1);
    checkOutput("add_show_state", 32'(state), 32'd2);
    checkOutput("add_display",    32'(display_value), 32'h46);
    idleCycle();
    checkOutput("add_valid_lo",   32'(result_valid), 32'd0);
    applyStimulus(K_CLR);
    checkOutput("clr_result",     32'(result), 32'h0);
    checkOutput("clr_state",      32'(state), 32'd0);

    // Digit capacity and CE in ENTER_A
    applyStimulus(5'h1);
    applyStimulus(5'h2);
    applyStimulus(5'h3);
    applyStimulus(5'h4);
    applyStimulus(5'h5);
    checkOutput("cap_a",          32'(operand_a), 32'h1234);
    applyStimulus(K_CE);
    checkOutput("ce_a",           32'(operand_a), 32'h0);
    checkOutput("ce_a_state",     32'(state), 32'd0);

    // Add carry-out, then digit restarts from SHOW_RESULT
    applyStimulus(5'hF);
    applyStimulus(5'hF);
    applyStimulus(5'hF);
    applyStimulus(5'hF);
    applyStimulus(K_ADD);
    applyStimulus(5'h1);
    applyStimulus(K_EXE);
    checkOutput("carry_result",   32'(result), 32'h0);
    checkOutput("carry_ovf",      32'(overflow), 32'd1);
    applyStimulus(K_EXE);
    checkOutput("exe_show_ovf",   32'(overflow), 32'd1);
    checkOutput("exe_show_valid", 32'(result_valid), 32'd0);
    applyStimulus(5'h7);
    checkOutput("restart_a",      32'(operand_a), 32'h7);
    checkOutput("restart_b",      32'(operand_b), 32'h0);
    checkOutput("restart_ovf",    32'(overflow), 32'd0);
    checkOutput("restart_state",  32'(state), 32'd0);

    // Subtract underflow
    applyStimulus(K_CLR);
    applyStimulus(5'h3);
    applyStimulus(K_SUB);
    applyStimulus(5'h5);
    applyStimulus(K_EXE);
    checkOutput("sub_result",     32'(result), 32'hFFFE);
    checkOutput("sub_ovf",        32'(overflow), 32'd1);

    // 0x100 * 0x100 overflows
    applyStimulus(K_CLR);
    applyStimulus(5'h1);
    applyStimulus(5'h0);
    applyStimulus(5'h0);
    applyStimulus(K_MULT);
    applyStimulus(5'h1);
    applyStimulus(5'h0);
    applyStimulus(5'h0);
    applyStimulus(K_EXE);
    checkOutput("mult_result",    32'(result), 32'h0);
    checkOutput("mult_ovf",       32'(overflow), 32'd1);
    applyStimulus(K_CE);
    checkOutput("ce_show_state",  32'(state), 32'd0);
    checkOutput("ce_show_a",      32'(operand_a), 32'h0);
    checkOutput("ce_show_ovf",    32'(overflow), 32'd0);

    // Non-overflowing mult and AND
    applyStimulus(5'h3);
    applyStimulus(K_MULT);
    applyStimulus(5'h5);
    applyStimulus(K_EXE);
    checkOutput("mult_small",     32'(result), 32'hF);
    checkOutput("mult_small_ovf", 32'(overflow), 32'd0);
    applyStimulus(K_CLR);
    applyStimulus(5'hC);
    applyStimulus(K_AND);
    applyStimulus(5'hA);
    applyStimulus(K_EXE);
    checkOutput("and_result",     32'(result), 32'h8);
    checkOutput("and_op",         32'(op_code), 32'd3);

    // Operator replacement, then chained OR with CE in ENTER_B
    applyStimulus(K_CLR);
    applyStimulus(5'h6);
    applyStimulus(K_ADD);
    applyStimulus(K_SUB);
    checkOutput("op_replace",     32'(op_code), 32'd1);
    applyStimulus(5'h2);
    applyStimulus(K_ADD);
    checkOutput("op_locked",      32'(op_code), 32'd1);
    applyStimulus(K_EXE);
    checkOutput("sub_chain_res",  32'(result), 32'h4);
    applyStimulus(K_OR);
    checkOutput("chain_a",        32'(operand_a), 32'h4);
    checkOutput("chain_state",    32'(state), 32'd1);
    checkOutput("chain_op",       32'(op_code), 32'd4);
    applyStimulus(5'h9);
    applyStimulus(K_CE);
    checkOutput("ce_b",           32'(operand_b), 32'h0);
    checkOutput("ce_b_state",     32'(state), 32'd1);
    checkOutput("ce_b_display",   32'(display_value), 32'h4);
    applyStimulus(5'h1);
    applyStimulus(K_EXE);
    checkOutput("or_result",      32'(result), 32'h5);

    // EXE with no B digits, invalid key in SHOW_RESULT, reset over sel
    applyStimulus(K_CLR);
    applyStimulus(5'h9);
    applyStimulus(K_ADD);
    applyStimulus(K_EXE);
    checkOutput("empty_b_result", 32'(result), 32'h9);
    applyStimulus(5'h1F);
    checkOutput("invalid_show_r", 32'(result), 32'h9);
    checkOutput("invalid_show_s", 32'(state), 32'd2);
    applyStimulus(5'h5);
    rst = 1'b1;
    sel = 1'b1;
    val = 5'h05;
    idleCycle();
    rst = 1'b0;
    sel = 1'b0;
    val = 5'h00;
    checkOutput("rst_sel_state",  32'(state), 32'd0);
    checkOutput("rst_sel_a",      32'(operand_a), 32'h0);
    checkOutput("rst_sel_result", 32'(result), 32'h0);
    checkOutput("rst_sel_disp",   32'(display_value), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
